univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 92 +++++++++
 tb/tb_univ_shift_reg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Brief    : Universal shift register with bidirectional shifting, parallel
//            load and a saturating occupancy counter.
// Revision : 1.0  initial release
// ============================================================================
module univ_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         sin_r,
  input  logic [WIDTH-1:0]         sin_l,
  input  logic [WIDTH*DEPTH-1:0]   pin,
  output logic [WIDTH-1:0]         sout_r,
  output logic [WIDTH-1:0]         sout_l,
  output logic [WIDTH*DEPTH-1:0]   pout,
  output logic [CW-1:0]            count,
  output logic                     full,
  output logic                     empty
);

  localparam logic [1:0]    c_mode_hold  = 2'b00;
  localparam logic [1:0]    c_mode_right = 2'b01;
  localparam logic [1:0]    c_mode_left  = 2'b10;
  localparam logic [1:0]    c_mode_load  = 2'b11;
  localparam logic [CW-1:0] c_depth      = CW'(DEPTH);
  localparam logic [CW-1:0] c_zero       = '0;

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [CW-1:0]    r_count;

  // The counter only saturates; data always moves and the outgoing word drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
      r_count <= '0;
    end else if (en) begin
      case (mode)
        c_mode_right: begin
          r_stage[0] <= sin_r;
          for (int k = 1; k < DEPTH; k++) begin
            r_stage[k] <= r_stage[k-1];
          end
          if (r_count != c_depth) begin
            r_count <= r_count + 1'b1;
          end
        end
        c_mode_left: begin
          r_stage[DEPTH-1] <= sin_l;
          for (int k = 0; k < DEPTH - 1; k++) begin
            r_stage[k] <= r_stage[k+1];
          end
          if (r_count != c_zero) begin
            r_count <= r_count - 1'b1;
          end
        end
        c_mode_load: begin
          for (int k = 0; k < DEPTH; k++) begin
            r_stage[k] <= pin[k*WIDTH +: WIDTH];
          end
          r_count <= c_depth;
        end
        c_mode_hold: begin
        end
        default: begin
        end
      endcase
    end
  end

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_pack
      assign pout[k*WIDTH +: WIDTH] = r_stage[k];
    end
  endgenerate

  assign sout_r = r_stage[DEPTH-1];
  assign sout_l = r_stage[0];
  assign count  = r_count;
  assign full   = (r_count == c_depth);
  assign empty  = (r_count == c_zero);

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_reg
// Brief    : Self-checking bench: directed cases on a 1x4 and an 8x4 instance,
//            plus randomized traffic against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_univ_shift_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance (1 bit x 4 stages)
  logic       d_rst_n = 1'b0, d_en = 1'b0;
  logic [1:0] d_mode = 2'b00;
  logic       d_sin_r = 1'b0, d_sin_l = 1'b0;
  logic [3:0] d_pin = '0, d_pout;
  logic       d_sout_r, d_sout_l, d_full, d_empty;
  logic [2:0] d_count;

  univ_shift_reg u_dut_d (
    .clk(clk), .rst_n(d_rst_n), .en(d_en), .mode(d_mode),
    .sin_r(d_sin_r), .sin_l(d_sin_l), .pin(d_pin),
    .sout_r(d_sout_r), .sout_l(d_sout_l), .pout(d_pout),
    .count(d_count), .full(d_full), .empty(d_empty)
  );

  // Byte-wide instance (8 bits x 4 stages)
  logic        w_rst_n = 1'b0, w_en = 1'b0;
  logic [1:0]  w_mode = 2'b00;
  logic [7:0]  w_sin_r = '0, w_sin_l = '0, w_sout_r, w_sout_l;
  logic [31:0] w_pin = '0, w_pout;
  logic [2:0]  w_count;
  logic        w_full, w_empty;

  univ_shift_reg #(.WIDTH(8), .DEPTH(4)) u_dut_w (
    .clk(clk), .rst_n(w_rst_n), .en(w_en), .mode(w_mode),
    .sin_r(w_sin_r), .sin_l(w_sin_l), .pin(w_pin),
    .sout_r(w_sout_r), .sout_l(w_sout_l), .pout(w_pout),
    .count(w_count), .full(w_full), .empty(w_empty)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: index 0 is stage 0; a right shift pushes at the front.
  logic [7:0] q[$];
  int         mcount;

  task automatic model_apply(input logic rst, input logic en, input logic [1:0] md,
                             input logic [7:0] sr, input logic [7:0] sl, input logic [31:0] p);
    if (!rst) begin
      q = {8'h00, 8'h00, 8'h00, 8'h00};
      mcount = 0;
    end else if (en) begin
      case (md)
        2'b01: begin
          q.push_front(sr);
          void'(q.pop_back());
          mcount = (mcount < 4) ? mcount + 1 : 4;
        end
        2'b10: begin
          q.push_back(sl);
          void'(q.pop_front());
          mcount = (mcount > 0) ? mcount - 1 : 0;
        end
        2'b11: begin
          for (int k = 0; k < 4; k++) q[k] = p[k*8 +: 8];
          mcount = 4;
        end
        default: ;
      endcase
    end
  endtask

  task automatic step_w(input string tag, input logic rst, input logic en, input logic [1:0] md,
                        input logic [7:0] sr, input logic [7:0] sl, input logic [31:0] p);
    logic [31:0] exp_pout;
    w_rst_n = rst; w_en = en; w_mode = md; w_sin_r = sr; w_sin_l = sl; w_pin = p;
    @(posedge clk); #1;
    model_apply(rst, en, md, sr, sl, p);
    for (int k = 0; k < 4; k++) exp_pout[k*8 +: 8] = q[k];
    check({tag, ".pout"},   64'(w_pout),   64'(exp_pout));
    check({tag, ".count"},  64'(w_count),  64'(mcount));
    check({tag, ".full"},   64'(w_full),   64'(mcount == 4));
    check({tag, ".empty"},  64'(w_empty),  64'(mcount == 0));
    check({tag, ".sout_r"}, 64'(w_sout_r), 64'(q[3]));
    check({tag, ".sout_l"}, 64'(w_sout_l), 64'(q[0]));
  endtask

  task automatic step_d(input logic rst, input logic en, input logic [1:0] md,
                        input logic sr, input logic sl, input logic [3:0] p);
    d_rst_n = rst; d_en = en; d_mode = md; d_sin_r = sr; d_sin_l = sl; d_pin = p;
    @(posedge clk); #1;
  endtask

  logic       bits_in  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic       sout_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] left_exp [4] = '{8'hBB, 8'hCC, 8'hDD, 8'h00};

  initial begin
    q = {8'h00, 8'h00, 8'h00, 8'h00};
    mcount = 0;

    // ---------------- default instance ----------------
    step_d(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
    check("rst.pout",   64'(d_pout),   64'h0);
    check("rst.count",  64'(d_count),  64'd0);
    check("rst.full",   64'(d_full),   64'd0);
    check("rst.empty",  64'(d_empty),  64'd1);
    check("rst.sout_r", 64'(d_sout_r), 64'd0);
    check("rst.sout_l", 64'(d_sout_l), 64'd0);

    for (int i = 0; i < 4; i++) begin
      step_d(1'b1, 1'b1, 2'b01, bits_in[i], 1'b0, 4'h0);
      check($sformatf("sr%0d.sout_r", i), 64'(d_sout_r), 64'(sout_exp[i]));
    end
    // Stage 3 holds the first word, stage 0 the last.
    check("sr.pout",  64'(d_pout),  64'b1011);
    check("sr.count", 64'(d_count), 64'd4);
    check("sr.full",  64'(d_full),  64'd1);

    for (int i = 0; i < 3; i++) step_d(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
    check("satfull.count", 64'(d_count), 64'd4);
    check("satfull.pout",  64'(d_pout),  64'b1000);

    for (int i = 0; i < 5; i++) begin
      step_d(1'b1, 1'b0, 2'b01, i[0], 1'b0, 4'h0);
      check($sformatf("hold%0d.pout", i),  64'(d_pout),  64'b1000);
      check($sformatf("hold%0d.count", i), 64'(d_count), 64'd4);
    end

    for (int i = 0; i < 5; i++) begin
      step_d(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 4'h0);
      check($sformatf("sl%0d.count", i), 64'(d_count), 64'((i < 4) ? 3 - i : 0));
    end
    check("satempty.empty", 64'(d_empty), 64'd1);
    check("satempty.pout",  64'(d_pout),  64'b0000);

    step_d(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 4'b1111);
    check("load.pout", 64'(d_pout), 64'hF);
    step_d(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b1111);
    check("midrst.pout",  64'(d_pout),  64'h0);
    check("midrst.count", 64'(d_count), 64'd0);
    check("midrst.empty", 64'(d_empty), 64'd1);
    step_d(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'b1111);
    check("resume.pout",  64'(d_pout),  64'b0001);
    check("resume.count", 64'(d_count), 64'd1);
    d_en = 1'b0;

    // ---------------- byte-wide instance ----------------
    step_w("wrst", 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 32'h0);
    step_w("wload", 1'b1, 1'b1, 2'b11, 8'h00, 8'h00, 32'hDDCCBBAA);
    check("wload.sout_l", 64'(w_sout_l), 64'hAA);
    check("wload.sout_r", 64'(w_sout_r), 64'hDD);
    for (int i = 0; i < 4; i++) begin
      step_w($sformatf("wsl%0d", i), 1'b1, 1'b1, 2'b10, 8'h00, 8'h00, 32'h0);
      check($sformatf("wsl%0d.sout_l_const", i), 64'(w_sout_l), 64'(left_exp[i]));
      check($sformatf("wsl%0d.count_const", i), 64'(w_count), 64'(3 - i));
    end
    check("wsl.empty_const", 64'(w_empty), 64'd1);

    // Back-to-back direction reversal with distinct words on each side
    for (int i = 0; i < 10; i++) begin
      step_w($sformatf("alt%0d", i), 1'b1, 1'b1, i[0] ? 2'b10 : 2'b01,
             8'(8'h10 + i), 8'(8'hE0 + i), 32'h0);
    end

    // Randomized traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      step_w($sformatf("rnd%0d", i), ($urandom_range(0, 24) != 0), ($urandom_range(0, 4) != 0),
             2'($urandom), 8'($urandom), 8'($urandom), 32'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
